eth_frame_tx: RTL

ETH_FRAME_TX -- requirements
Module: eth_frame_tx

---
 rtl/eth_pkg.sv | 36 +++
 rtl/eth_frame_tx_if.sv | 37 +++
 rtl/eth_crc32_d64.sv | 26 ++
 rtl/eth_frame_tx.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet frame transmitter.
package eth_pkg;

    localparam int MAC_W  = 48;
    localparam int BEAT_W = 64;
    localparam int TYPE_W = 16;
    localparam int CRC_W  = 32;

    // CRC-32 generator polynomial (normal, non-reflected form), default seed
    // and the final XOR applied to the register before it goes on the wire.
    localparam logic [CRC_W-1:0] CRC32_POLY   = 32'h04C1_1DB7;
    localparam logic [CRC_W-1:0] CRC32_INIT   = 32'hFFFF_FFFF;
    localparam logic [CRC_W-1:0] CRC32_XOROUT = 32'hFFFF_FFFF;

    // Transmit sequencer states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HDR0    = 3'd1,
        HDR1    = 3'd2,
        PAYLOAD = 3'd3,
        CRC     = 3'd4
    } tx_state_t;

    // First header beat: full destination MAC plus the top 16 bits of source.
    function automatic logic [BEAT_W-1:0] hdr0_beat(input logic [MAC_W-1:0] dst,
                                                    input logic [MAC_W-1:0] src);
        return {dst, src[47:32]};
    endfunction

    // Second header beat: rest of source MAC, type field, zero padding.
    function automatic logic [BEAT_W-1:0] hdr1_beat(input logic [MAC_W-1:0]  src,
                                                    input logic [TYPE_W-1:0] etype);
        return {src[31:0], etype, 16'h0000};
    endfunction

endpackage

// File: rtl/eth_frame_tx_if.sv
// Descriptor, payload and frame-output signals of the frame transmitter.
// Handshake: a payload word moves on a rising edge where plVld & plRdy are
// both high; plRdy never depends on plVld. Frame beats on outData are valid
// while outVld is high, marked by outSop (first) and outEop (last).
interface eth_frame_tx_if #(
    parameter int LEN_W = 8
);
    import eth_pkg::*;

    logic                start;
    logic [MAC_W-1:0]    dstAddr;
    logic [MAC_W-1:0]    srcAddr;
    logic [TYPE_W-1:0]   etherType;
    logic [LEN_W-1:0]    payloadLen;
    logic [BEAT_W-1:0]   plData;
    logic                plVld;
    logic                plRdy;
    logic [BEAT_W-1:0]   outData;
    logic                outSop;
    logic                outEop;
    logic                outVld;
    logic                busy;
    logic                underrunErr;

    // Frame source side: issues descriptors, supplies payload, sees frames.
    modport master (
        output start, dstAddr, srcAddr, etherType, payloadLen, plData, plVld,
        input  plRdy, outData, outSop, outEop, outVld, busy, underrunErr
    );

    // Transmitter side.
    modport slave (
        input  start, dstAddr, srcAddr, etherType, payloadLen, plData, plVld,
        output plRdy, outData, outSop, outEop, outVld, busy, underrunErr
    );

endinterface

// File: rtl/eth_crc32_d64.sv
// Combinational CRC-32 step over one 64-bit beat, bit 63 shifted in first,
// no reflection. Output is the raw register value (no final XOR).
module eth_crc32_d64
    import eth_pkg::*;
(
    input  logic [CRC_W-1:0]  crc_i,
    input  logic [BEAT_W-1:0] data_i,
    output logic [CRC_W-1:0]  crc_o
);

    // Unrolled serial LFSR: 64 shift steps, MSB of the beat first.
    always_comb begin
        logic [CRC_W-1:0] c;
        logic             fb;
        c = crc_i;
        for (int i = BEAT_W - 1; i >= 0; i--) begin
            fb = c[CRC_W-1] ^ data_i[i];
            c  = {c[CRC_W-2:0], 1'b0};
            if (fb) begin
                c = c ^ CRC32_POLY;
            end
        end
        crc_o = c;
    end

endmodule

// File: rtl/eth_frame_tx.sv
// Ethernet frame transmitter: sends a two-beat MAC header, payloadLen payload
// words taken over a valid/ready port, then a CRC-32 trailer beat. A payload
// stall inside a frame aborts it with an inverted CRC and an error pulse.
module eth_frame_tx
    import eth_pkg::*;
#(
    parameter int               LEN_W    = 8,
    parameter logic [CRC_W-1:0] CRC_INIT = CRC32_INIT
) (
    input  logic          clk,
    input  logic          resetN,
    eth_frame_tx_if.slave tx,
    output tx_state_t     state_o
);

    tx_state_t           state_q, state_d;
    logic [LEN_W-1:0]    cnt_q, cnt_d;
    logic [CRC_W-1:0]    crc_q, crc_d;
    logic [BEAT_W-1:0]   data_q, data_d;
    logic                sop_q, sop_d;
    logic                eop_q, eop_d;
    logic                vld_q, vld_d;
    logic                busy_q, busy_d;
    logic                uerr_q, uerr_d;

    logic [MAC_W-1:0]    dst_q;
    logic [MAC_W-1:0]    src_q;
    logic [TYPE_W-1:0]   type_q;
    logic                lat_en;

    logic [BEAT_W-1:0]   beat;
    logic [CRC_W-1:0]    crc_nxt;

    // Select the beat the current state would emit, so the CRC can fold it in.
    always_comb begin
        beat = hdr0_beat(dst_q, src_q);
        case (state_q)
            HDR1:    beat = hdr1_beat(src_q, type_q);
            PAYLOAD: beat = tx.plData;
            default: beat = hdr0_beat(dst_q, src_q);
        endcase
    end

    eth_crc32_d64 u_crc (
        .crc_i  (crc_q),
        .data_i (beat),
        .crc_o  (crc_nxt)
    );

    // Next-state and registered-output logic; each state loads its beat into
    // the output register on the edge that leaves it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        crc_d   = crc_q;
        data_d  = data_q;
        sop_d   = 1'b0;
        eop_d   = 1'b0;
        vld_d   = 1'b0;
        busy_d  = busy_q;
        uerr_d  = 1'b0;
        lat_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (tx.start) begin
                    lat_en  = 1'b1;
                    cnt_d   = tx.payloadLen;
                    crc_d   = CRC_INIT;
                    busy_d  = 1'b1;
                    state_d = HDR0;
                end
            end
            HDR0: begin
                data_d  = beat;
                sop_d   = 1'b1;
                vld_d   = 1'b1;
                crc_d   = crc_nxt;
                state_d = HDR1;
            end
            HDR1: begin
                data_d  = beat;
                vld_d   = 1'b1;
                crc_d   = crc_nxt;
                state_d = (cnt_q == '0) ? CRC : PAYLOAD;
            end
            PAYLOAD: begin
                if (cnt_q == '0) begin
                    // Unreachable in normal flow; never wrap the count.
                    state_d = CRC;
                end else if (tx.plVld) begin
                    data_d = beat;
                    vld_d  = 1'b1;
                    crc_d  = crc_nxt;
                    cnt_d  = cnt_q - LEN_W'(1);
                    if (cnt_q == LEN_W'(1)) begin
                        state_d = CRC;
                    end
                end else begin
                    // Underrun: close the frame with a deliberately wrong CRC.
                    data_d  = {32'h0, ~(crc_q ^ CRC32_XOROUT)};
                    eop_d   = 1'b1;
                    vld_d   = 1'b1;
                    uerr_d  = 1'b1;
                    busy_d  = 1'b0;
                    crc_d   = CRC_INIT;
                    state_d = IDLE;
                end
            end
            CRC: begin
                data_d  = {32'h0, crc_q ^ CRC32_XOROUT};
                eop_d   = 1'b1;
                vld_d   = 1'b1;
                busy_d  = 1'b0;
                crc_d   = CRC_INIT;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                crc_d   = CRC_INIT;
                state_d = IDLE;
            end
        endcase
    end

    // State, counter, CRC and output registers with asynchronous reset.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            crc_q   <= CRC_INIT;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
            uerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            crc_q   <= crc_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
            uerr_q  <= uerr_d;
        end
    end

    // Descriptor capture when a start is accepted in IDLE.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            dst_q  <= '0;
            src_q  <= '0;
            type_q <= '0;
        end else if (lat_en) begin
            dst_q  <= tx.dstAddr;
            src_q  <= tx.srcAddr;
            type_q <= tx.etherType;
        end
    end

    assign tx.plRdy       = (state_q == PAYLOAD) && (cnt_q != '0);
    assign tx.outData     = data_q;
    assign tx.outSop      = sop_q;
    assign tx.outEop      = eop_q;
    assign tx.outVld      = vld_q;
    assign tx.busy        = busy_q;
    assign tx.underrunErr = uerr_q;
    assign state_o        = state_q;

endmodule
